// File: rtl/fifo_rd_ctrl.sv
// fifo_rd_ctrl: read-domain controller of an asynchronous FIFO.
// Brings the write-side Gray pointer into the read clock domain and keeps
// the read pointer. It produces a registered empty flag and a registered
// fill level, and returns its own Gray pointer to the write side.
// Define FIFO_RD_ALMOST_EMPTY_EN to add the registered almost_empty output.
module fifo_rd_ctrl #(
  parameter int addr_size   = 4,
  parameter int sync_stages = 2,
  parameter int ae_thresh   = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rd_en,
  input  logic [addr_size:0]   wr_gray_async,
  output logic                 rd_valid,
  output logic [addr_size-1:0] rd_addr,
  output logic [addr_size:0]   rd_gray,
  output logic                 empty,
`ifdef FIFO_RD_ALMOST_EMPTY_EN
  output logic [addr_size:0]   level,
  output logic                 almost_empty
`else
  output logic [addr_size:0]   level
`endif
);

  localparam int PW = addr_size + 1;

  logic [addr_size:0] sync_q [sync_stages];
  logic [addr_size:0] wr_gray_s;
  logic [addr_size:0] wr_bin_s;
  logic [addr_size:0] rd_bin;
  logic [addr_size:0] rd_bin_nxt;
  logic [addr_size:0] rd_gray_nxt;
  logic [addr_size:0] level_nxt;

  // Plain flop chain with no logic between stages, so the Gray value settles cleanly
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < sync_stages; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= wr_gray_async;
      for (int i = 1; i < sync_stages; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign wr_gray_s = sync_q[sync_stages-1];

  // Gray to binary: bit i is the XOR of all Gray bits from the MSB down to bit i
  always_comb begin
    wr_bin_s = '0;
    for (int i = 0; i <= addr_size; i++) wr_bin_s[i] = ^(wr_gray_s >> i);
  end

  assign rd_valid    = rd_en & ~empty;
  assign rd_bin_nxt  = rd_bin + PW'(rd_valid);
  assign rd_gray_nxt = rd_bin_nxt ^ (rd_bin_nxt >> 1);
  assign level_nxt   = wr_bin_s - rd_bin_nxt;
  assign rd_addr     = rd_bin[addr_size-1:0];

  // Pointer, empty and level update. Empty is computed from the next pointer,
  // so a read that takes the last word closes the read window on the same edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_bin  <= '0;
      rd_gray <= '0;
      empty   <= 1'b1;
      level   <= '0;
    end else begin
      rd_bin  <= rd_bin_nxt;
      rd_gray <= rd_gray_nxt;
      empty   <= (rd_gray_nxt == wr_gray_s);
      level   <= level_nxt;
    end
  end

`ifdef FIFO_RD_ALMOST_EMPTY_EN
  localparam logic [addr_size:0] AE_THRESH_W = ae_thresh[addr_size:0];

  // Almost-empty flag, registered together with level
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) almost_empty <= 1'b1;
    else      almost_empty <= (level_nxt <= AE_THRESH_W);
  end
`endif

endmodule
